// File: rtl/adc_serial_reader.sv
// adc_serial_reader: SPI-style master that reads one 12-bit conversion per frame from an ADCS7476-class ADC.
// Optional macro ADC_FRAME_CHECK_EN adds frame_err, flagging nonzero leading bits [15:12].
`timescale 1ns/1ps
module adc_serial_reader #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned QUIET_CYC = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        sdata,
  output logic        cs_n,
  output logic        sclk,
  output logic [11:0] sample,
`ifdef ADC_FRAME_CHECK_EN
  output logic        frame_err,
`endif
  output logic        done
);

  // Without the frame check only the low 12 bits are kept; the leading zeros shift out the top.
`ifdef ADC_FRAME_CHECK_EN
  localparam int unsigned SHIFT_W = 16;
`else
  localparam int unsigned SHIFT_W = 12;
`endif

  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] QUIET_LAST = 8'(QUIET_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    GAP
  } state_t;

  state_t               r_state;
  logic [7:0]           r_div;
  logic [7:0]           r_quiet;
  logic [4:0]           r_bits;
  logic [SHIFT_W-1:0]   r_shift;
  logic                 r_cs_n;
  logic                 r_sclk;
  logic [11:0]          r_sample;
  logic                 r_done;
`ifdef ADC_FRAME_CHECK_EN
  logic                 r_frame_err;
`endif

  logic w_div_last;
  assign w_div_last = (r_div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_div       <= '0;
      r_quiet     <= '0;
      r_bits      <= '0;
      r_shift     <= '0;
      r_cs_n      <= 1'b1;
      r_sclk      <= 1'b1;
      r_sample    <= '0;
      r_done      <= 1'b0;
`ifdef ADC_FRAME_CHECK_EN
      r_frame_err <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cs_n <= 1'b1;
          r_sclk <= 1'b1;
          r_div  <= '0;
          r_bits <= '0;
          if (enable) begin
            r_state <= CS_SETUP;
            r_cs_n  <= 1'b0;
          end
        end
        CS_SETUP: begin
          if (w_div_last) begin
            r_div   <= '0;
            r_sclk  <= 1'b0;
            r_state <= SHIFT;
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        SHIFT: begin
          // Capture on the cycle sclk is driven high; leave after the 16th high half-period.
          if (w_div_last) begin
            r_div <= '0;
            if (!r_sclk) begin
              r_sclk  <= 1'b1;
              r_shift <= {r_shift[SHIFT_W-2:0], sdata};
              r_bits  <= r_bits + 5'd1;
            end else if (r_bits == 5'd16) begin
              r_state <= CS_HOLD;
            end else begin
              r_sclk <= 1'b0;
            end
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        CS_HOLD: begin
          if (w_div_last) begin
            r_div    <= '0;
            r_state  <= GAP;
            r_cs_n   <= 1'b1;
            r_done   <= 1'b1;
            r_sample <= r_shift[11:0];
`ifdef ADC_FRAME_CHECK_EN
            r_frame_err <= |r_shift[15:12];
`endif
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        GAP: begin
          if (r_quiet == QUIET_LAST) begin
            r_quiet <= '0;
            r_state <= IDLE;
          end else begin
            r_quiet <= r_quiet + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cs_n   = r_cs_n;
  assign sclk   = r_sclk;
  assign sample = r_sample;
  assign done   = r_done;
`ifdef ADC_FRAME_CHECK_EN
  assign frame_err = r_frame_err;
`endif

endmodule

// File: tb/tb_adc_serial_reader.sv
// tb_adc_serial_reader: scoreboard bench with a behavioural ADC model and frame-timing expectations
// for a default instance (CLK_DIV=4, QUIET_CYC=8) and a fast one (CLK_DIV=2, QUIET_CYC=1).
`timescale 1ns/1ps
module tb_adc_serial_reader;

  typedef struct {
    logic [11:0] s;
    logic        err;
    int          at;
  } exp_t;

  logic       clk   = 1'b0;
  logic [1:0] rst_v = 2'b11;
  logic [1:0] en_v  = 2'b00;
  int ecnt  = 0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) ecnt++;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gp
    localparam int D = (g == 0) ? 4 : 2;
    localparam int Q = (g == 0) ? 8 : 1;
    logic        cs_n, sclk, done;
    logic        sdata = 1'b0;
    logic [11:0] sample;
`ifdef ADC_FRAME_CHECK_EN
    logic        frame_err;
`endif
    exp_t        sb_q[$];
    logic [15:0] adc_q[$];
    logic [15:0] cur = '0;
    int idx = -1, rises = 0, lows = 0, hi = 0, last_rise = -1, nd = 0;
    bit per_ok = 1'b1, gap_arm = 1'b0;
    logic pcs = 1'b1, psclk = 1'b1;
    exp_t e;

    adc_serial_reader #(.CLK_DIV(D), .QUIET_CYC(Q)) u_dut (
      .clk(clk), .rst(rst_v[g]), .enable(en_v[g]), .sdata(sdata),
      .cs_n(cs_n), .sclk(sclk), .sample(sample),
`ifdef ADC_FRAME_CHECK_EN
      .frame_err(frame_err),
`endif
      .done(done)
    );

    // ADC model (new bit on each sclk fall) plus monitor, sampled 1 ns after each clk edge.
    always @(posedge clk) begin
      #1;
      if (rst_v[g]) begin
        rises = 0; lows = 0; hi = 0; last_rise = -1; per_ok = 1'b1; gap_arm = 1'b0; idx = -1;
      end else begin
        if (done) begin
          nd++;
          if (sb_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_done%0d: got done, expected none (edge %0d)", g, ecnt);
          end else begin
            e = sb_q.pop_front();
            chk($sformatf("sample%0d", g), sample, e.s);
            chk($sformatf("done_time%0d", g), ecnt, e.at);
            chk($sformatf("cs_low_len%0d", g), lows, 34 * D);
            chk($sformatf("sclk_rises%0d", g), rises, 16);
            chk($sformatf("sclk_period%0d", g), per_ok, 1);
`ifdef ADC_FRAME_CHECK_EN
            chk($sformatf("frame_err%0d", g), frame_err, e.err);
`endif
          end
          lows = 0; rises = 0; last_rise = -1; per_ok = 1'b1; hi = 0;
          gap_arm = en_v[g];
        end
        if (pcs && !cs_n) begin
          cur = (adc_q.size() > 0) ? adc_q.pop_front() : 16'h0000;
          idx = 15;
          // cs_n stays high for the QUIET_CYC gap plus the IDLE cycle that restarts the frame.
          if (gap_arm) chk($sformatf("cs_gap%0d", g), hi, Q + 1);
          gap_arm = 1'b0;
        end
        if (cs_n) hi++; else lows++;
        if (!cs_n && psclk && !sclk && idx >= 0) begin
          sdata = cur[idx];
          idx--;
        end
        if (!cs_n && !psclk && sclk) begin
          if (last_rise >= 0 && ecnt - last_rise != 2 * D) per_ok = 1'b0;
          last_rise = ecnt;
          rises++;
        end
      end
      pcs = cs_n;
      psclk = sclk;
    end
  end

  task automatic push_frame(input int g, input logic [15:0] f, input int t0);
    exp_t x;
    x.s   = f[11:0];
    x.err = |f[15:12];
    if (g == 0) begin
      x.at = t0 + 34 * 4;
      gp[0].adc_q.push_back(f);
      gp[0].sb_q.push_back(x);
    end else begin
      x.at = t0 + 34 * 2;
      gp[1].adc_q.push_back(f);
      gp[1].sb_q.push_back(x);
    end
  endtask

  initial begin
    logic [15:0] f;
    int t0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n0", gp[0].cs_n, 1);
    chk("rst_sclk0", gp[0].sclk, 1);
    chk("rst_sample0", gp[0].sample, 0);
    chk("rst_done0", gp[0].done, 0);
    chk("rst_cs_n1", gp[1].cs_n, 1);
    chk("rst_sclk1", gp[1].sclk, 1);
`ifdef ADC_FRAME_CHECK_EN
    chk("rst_frame_err0", gp[0].frame_err, 0);
`endif
    rst_v = 2'b00;

    // Single frame from a one-cycle enable pulse.
    @(negedge clk); en_v[0] = 1'b1; t0 = ecnt + 1; push_frame(0, 16'h0ABC, t0);
    @(negedge clk); en_v[0] = 1'b0;
    repeat (170) @(negedge clk);
    chk("single_done_count", gp[0].nd, 1);

    // Back-to-back frames, enable dropped during the second frame's shift phase.
    @(negedge clk); en_v[0] = 1'b1; t0 = ecnt + 1;
    push_frame(0, 16'h0123, t0);
    push_frame(0, 16'h0FFF, t0 + 145);
    repeat (145 + 60) @(negedge clk);
    en_v[0] = 1'b0;
    repeat (250) @(negedge clk);
    chk("b2b_done_count", gp[0].nd, 3);
    chk("no_restart_after_drop", gp[0].lows, 0);

    // Reset at the 9th rising sclk edge aborts the frame; a fresh frame follows.
    @(negedge clk); en_v[0] = 1'b1;
    gp[0].adc_q.push_back(16'h0555);
    for (int i = 0; i < 400 && gp[0].rises < 9; i++) @(negedge clk);
    chk("rise9_reached", gp[0].rises, 9);
    rst_v[0] = 1'b1;
    @(posedge clk); #1;
    chk("abort_cs_n", gp[0].cs_n, 1);
    chk("abort_sclk", gp[0].sclk, 1);
    chk("abort_sample", gp[0].sample, 0);
    chk("abort_done", gp[0].done, 0);
    @(negedge clk); rst_v[0] = 1'b0; t0 = ecnt + 1;
    f = 16'($urandom);
    push_frame(0, f, t0);
    repeat (50) @(negedge clk);
    en_v[0] = 1'b0;
    repeat (200) @(negedge clk);
    chk("post_reset_done_count", gp[0].nd, 4);

    // Randomized single frames with random idle spacing.
    for (int k = 0; k < 6; k++) begin
      f = 16'($urandom);
      @(negedge clk); en_v[0] = 1'b1; t0 = ecnt + 1; push_frame(0, f, t0);
      @(negedge clk); en_v[0] = 1'b0;
      repeat (150 + $urandom_range(0, 15)) @(negedge clk);
    end

    // Leading-bit frames: nonzero upper nibble then a clean frame.
    @(negedge clk); en_v[0] = 1'b1; t0 = ecnt + 1;
    push_frame(0, 16'h5ABC, t0);
    push_frame(0, 16'h0001, t0 + 145);
    repeat (145 + 50) @(negedge clk);
    en_v[0] = 1'b0;
    repeat (250) @(negedge clk);

    // Fast instance: CLK_DIV=2, QUIET_CYC=1.
    @(negedge clk); en_v[1] = 1'b1; t0 = ecnt + 1;
    push_frame(1, 16'h0800, t0);
    push_frame(1, 16'($urandom), t0 + 70);
    repeat (70 + 20) @(negedge clk);
    en_v[1] = 1'b0;
    repeat (150) @(negedge clk);
    chk("fast_done_count", gp[1].nd, 2);

    chk("sb_empty0", gp[0].sb_q.size(), 0);
    chk("sb_empty1", gp[1].sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
